// File: rtl/regfile_pkg.sv
// Shared register-file encodings and types for the Y86-style decode/write-back slice.
// Pure declarations: no timing, no flow control.
package regfile_pkg;
    localparam int DATA_W_DEF   = 64;
    localparam int NUM_REGS_DEF = 16;
    localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    localparam logic [ADDR_W_DEF-1:0] RNONE = ADDR_W_DEF'(NUM_REGS_DEF - 1);

    localparam logic [3:0] IRRMOVL = 4'h2;
    localparam logic [3:0] IRMMOVL = 4'h4;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/regfile_sb_cnt.sv
// Per-register pending-write counter: +issues -retires each cycle, 1-cycle update latency.
// Never backpressures; flush clears, underflow clamps to 0 and pulses underflow.
module regfile_sb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] count,
    output logic             underflow
);
    localparam int SW = CNT_W + 2;

    logic signed [SW-1:0] sum;
    logic [CNT_W-1:0]     count_nxt;

    always_comb begin
        sum = $signed({2'b00, count}) + $signed({{CNT_W{1'b0}}, inc})
            - $signed({{CNT_W{1'b0}}, dec});
        underflow = !flush && (sum < 0);
        count_nxt = sum[CNT_W-1:0];
        if (flush || sum < 0)
            count_nxt = '0;
        else if (sum > $signed({2'b00, {CNT_W{1'b1}}}))
            count_nxt = {CNT_W{1'b1}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else
            count <= count_nxt;
    end
endmodule

// File: rtl/regfile_sb.sv
// Register file with E/M write-back, 0-cycle write bypass and RAW scoreboard; reads/writes 1-cycle store.
// Reads and writes never stall; stall only refuses an issue that would overflow a pending counter.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_ready,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_dstE,
    input  logic [ADDR_W-1:0]        iss_dstM,
    output logic                     stall,
    input  logic                     wbE_en,
    input  logic [ADDR_W-1:0]        wbE_addr,
    input  logic [DATA_W-1:0]        wbE_data,
    input  logic                     wbE_cnd,
    input  logic                     wbM_en,
    input  logic [ADDR_W-1:0]        wbM_addr,
    input  logic [DATA_W-1:0]        wbM_data,
    input  logic                     flush,
    output logic                     sb_err
);
    localparam int                NR     = NUM_REGS - 1;
    localparam logic [ADDR_W-1:0] RN_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [CNT_W+1:0]  CMAX   = {2'b00, {CNT_W{1'b1}}};

    logic              we_e, we_m, iss_ok;
    logic [DATA_W-1:0] regs [NR];
    logic [CNT_W-1:0]  cnt  [NR];
    logic [1:0]        ret  [NR];
    logic [1:0]        inc  [NR];
    logic [NR-1:0]     over;
    logic [NR-1:0]     uf;

    // Data writes are masked during reset so rd_data reads 0 while rst is high.
    assign we_m   = wbM_en && (wbM_addr != RN_IDX) && !rst;
    assign we_e   = wbE_en && wbE_cnd && (wbE_addr != RN_IDX) && !rst;
    assign stall  = (|over) && !flush && !rst;
    assign iss_ok = iss_valid && !stall;

    for (genvar r = 0; r < NR; r++) begin : g_reg
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(r);
        logic [1:0] pot;

        assign pot    = {1'b0, iss_valid && (iss_dstE == IDX)} + {1'b0, iss_valid && (iss_dstM == IDX)};
        // Retire frees the slot even when the cmov condition suppressed the data.
        assign ret[r] = {1'b0, wbE_en && (wbE_addr == IDX)} + {1'b0, wbM_en && (wbM_addr == IDX)};
        assign inc[r] = iss_ok ? pot : 2'd0;
        assign over[r] = (pot != 2'd0) &&
            (({2'b00, cnt[r]} + {{CNT_W{1'b0}}, pot}) > (CMAX + {{CNT_W{1'b0}}, ret[r]}));

        regfile_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .inc       (inc[r]),
            .dec       (ret[r]),
            .count     (cnt[r]),
            .underflow (uf[r])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sb_err <= 1'b0;
        else if (|uf)
            sb_err <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NR; r++)
                regs[r] <= '0;
        end else begin
            if (we_e && !(we_m && (wbM_addr == wbE_addr)))
                regs[wbE_addr] <= wbE_data;
            if (we_m)
                regs[wbM_addr] <= wbM_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              rdy;

        assign a = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            d   = '0;
            rdy = 1'b1;
            if (a < RN_IDX) begin
                if (we_m && (wbM_addr == a))
                    d = wbM_data;
                else if (we_e && (wbE_addr == a))
                    d = wbE_data;
                else
                    d = regs[a];
                rdy = (cnt[a] == '0) || ({2'b00, cnt[a]} == {{CNT_W{1'b0}}, ret[a]});
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = d;
        assign rd_ready[p]                 = rdy;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: driver queues expected outputs per cycle, monitor checks on negedge.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int NUM_RD = 2;
    localparam int AW     = ADDR_W_DEF;
    localparam int DW     = DATA_W_DEF;
    localparam reg_idx_t RN = RNONE;

    localparam int K_D0    = 0;
    localparam int K_D1    = 1;
    localparam int K_RDY   = 2;
    localparam int K_STALL = 3;
    localparam int K_ERR   = 4;

    typedef struct {
        int          cyc;
        string       nm;
        int          kind;
        logic [63:0] v;
    } item_t;

    logic                 clk;
    logic                 rst;
    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*DW-1:0] rd_data;
    logic [NUM_RD-1:0]    rd_ready;
    logic                 iss_valid;
    reg_idx_t             iss_dstE, iss_dstM;
    logic                 stall;
    logic                 wbE_en, wbE_cnd, wbM_en;
    reg_idx_t             wbE_addr, wbM_addr;
    word_t                wbE_data, wbM_data;
    logic                 flush;
    logic                 sb_err;

    item_t q[$];
    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .iss_valid(iss_valid), .iss_dstE(iss_dstE), .iss_dstM(iss_dstM), .stall(stall),
        .wbE_en(wbE_en), .wbE_addr(wbE_addr), .wbE_data(wbE_data), .wbE_cnd(wbE_cnd),
        .wbM_en(wbM_en), .wbM_addr(wbM_addr), .wbM_data(wbM_data),
        .flush(flush), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: compares everything queued for the current cycle.
    always @(negedge clk) begin
        item_t       it;
        logic [63:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            it = q.pop_front();
            case (it.kind)
                K_D0:    act = rd_data[DW-1:0];
                K_D1:    act = rd_data[2*DW-1:DW];
                K_RDY:   act = 64'(rd_ready);
                K_STALL: act = 64'(stall);
                default: act = 64'(sb_err);
            endcase
            total++;
            if (it.cyc != cyc || act !== it.v) begin
                bad++;
                $display("FAIL %s (cycle %0d): got %0h want %0h", it.nm, cyc, act, it.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input int kind, input logic [63:0] v, input string nm);
        item_t it;
        it.cyc = cyc; it.nm = nm; it.kind = kind; it.v = v;
        q.push_back(it);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input reg_idx_t a0, input reg_idx_t a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_dstE = RN; iss_dstM = RN;
        wbE_en = 1'b0; wbE_cnd = 1'b0; wbE_addr = RN; wbE_data = '0;
        wbM_en = 1'b0; wbM_addr = RN; wbM_data = '0;
        flush = 1'b0;
    endtask

    task automatic issue(input reg_idx_t e, input reg_idx_t m);
        iss_valid = 1'b1; iss_dstE = e; iss_dstM = m;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd(RN, RN);
        step();

        // Reset: writes and issues are ignored, outputs at reset values.
        wbM_en = 1'b1; wbM_addr = 4'd3; wbM_data = 64'h55;
        issue(4'd1, RN);
        rd(4'd3, RN);
        chk(K_D0, 64'h0, "rst_d0"); chk(K_D1, 64'h0, "rst_d1");
        chk(K_RDY, 64'h3, "rst_rdy"); chk(K_STALL, 64'h0, "rst_stall");
        chk(K_ERR, 64'h0, "rst_err");
        step();
        rst = 1'b0;
        idle();

        for (int r = 0; r < 15; r++) begin
            rd(AW'(r), RN);
            chk(K_D0, 64'h0, "init_d0"); chk(K_D1, 64'h0, "init_rnone_d1");
            chk(K_RDY, 64'h3, "init_rdy");
            step();
        end

        // Same-cycle E/M write to r3: M wins on bypass and in storage.
        issue(4'd3, 4'd3); rd(4'd3, RN);
        chk(K_STALL, 64'h0, "r3_iss_stall"); chk(K_RDY, 64'h3, "r3_iss_rdy");
        step();
        idle();
        wbE_en = 1'b1; wbE_cnd = 1'b1; wbE_addr = 4'd3; wbE_data = 64'h1111;
        wbM_en = 1'b1; wbM_addr = 4'd3; wbM_data = 64'h2222;
        rd(4'd3, 4'd3);
        chk(K_D0, 64'h2222, "byp_m_wins_d0"); chk(K_D1, 64'h2222, "byp_m_wins_d1");
        chk(K_RDY, 64'h3, "r3_retire_rdy");
        step();
        idle(); rd(4'd3, 4'd4);
        chk(K_D0, 64'h2222, "r3_stored"); chk(K_D1, 64'h0, "r4_clean");
        chk(K_RDY, 64'h3, "r3_free_rdy"); chk(K_ERR, 64'h0, "r3_no_err");
        step();

        // Suppressed cmov on r5 still frees the register.
        issue(4'd5, RN); rd(4'd5, RN);
        chk(K_STALL, 64'h0, "r5_iss_stall");
        step();
        idle(); rd(4'd5, RN);
        chk(K_RDY, 64'h2, "r5_pending_rdy");
        step();
        wbE_en = 1'b1; wbE_cnd = 1'b0; wbE_addr = 4'd5; wbE_data = 64'hAA;
        chk(K_D0, 64'h0, "cmov_no_byp"); chk(K_RDY, 64'h3, "r5_retiring_rdy");
        step();
        idle();
        chk(K_D0, 64'h0, "cmov_no_store"); chk(K_RDY, 64'h3, "r5_free_rdy");
        chk(K_ERR, 64'h0, "r5_no_err");
        step();

        // Fill r2 to 3 pending, then overflow behaviour.
        rd(4'd2, RN);
        for (int i = 0; i < 3; i++) begin
            issue(4'd2, RN);
            chk(K_STALL, 64'h0, "r2_fill_stall");
            step();
        end
        chk(K_STALL, 64'h1, "r2_overflow_stall"); chk(K_RDY, 64'h2, "r2_full_rdy");
        step();
        wbM_en = 1'b1; wbM_addr = 4'd2; wbM_data = 64'h22;
        chk(K_STALL, 64'h0, "r2_retire_issue_stall"); chk(K_D0, 64'h22, "r2_byp");
        chk(K_RDY, 64'h2, "r2_retire_rdy");
        step();
        wbM_en = 1'b0;
        chk(K_STALL, 64'h1, "r2_still3_stall"); chk(K_D0, 64'h22, "r2_stored");
        step();
        idle(); rd(4'd2, RN);
        wbM_en = 1'b1; wbM_addr = 4'd2; wbM_data = 64'h22;
        chk(K_RDY, 64'h2, "r2_drain3_rdy");
        step();
        chk(K_RDY, 64'h2, "r2_drain2_rdy");
        step();
        chk(K_RDY, 64'h3, "r2_drain1_rdy");
        step();
        idle();
        chk(K_RDY, 64'h3, "r2_empty_rdy"); chk(K_ERR, 64'h0, "r2_no_err");
        step();

        // Double issue to r4, then flush.
        issue(4'd4, 4'd4); rd(4'd4, RN);
        chk(K_STALL, 64'h0, "r4_dbl_stall"); chk(K_RDY, 64'h3, "r4_pre_rdy");
        step();
        chk(K_STALL, 64'h1, "r4_cnt2_stall"); chk(K_RDY, 64'h2, "r4_cnt2_rdy");
        step();
        flush = 1'b1;
        wbE_en = 1'b1; wbE_cnd = 1'b1; wbE_addr = 4'd4; wbE_data = 64'h44;
        chk(K_STALL, 64'h0, "flush_stall"); chk(K_D0, 64'h44, "flush_wr_byp");
        chk(K_RDY, 64'h2, "flush_cyc_rdy");
        step();
        idle();
        chk(K_RDY, 64'h3, "post_flush_rdy"); chk(K_D0, 64'h44, "flush_wr_stored");
        chk(K_ERR, 64'h0, "flush_no_err");
        step();

        // Write-back to RNONE is ignored.
        wbM_en = 1'b1; wbM_addr = RN; wbM_data = 64'hFF;
        rd(RN, 4'd4);
        chk(K_D0, 64'h0, "rnone_d0"); chk(K_D1, 64'h44, "rnone_r4");
        chk(K_RDY, 64'h3, "rnone_rdy");
        step();
        idle();
        chk(K_ERR, 64'h0, "rnone_no_err");
        step();

        // Retire with no pending write sets sticky sb_err; rst clears it.
        wbE_en = 1'b1; wbE_cnd = 1'b1; wbE_addr = 4'd7; wbE_data = 64'h77;
        rd(4'd7, RN);
        chk(K_D0, 64'h77, "r7_byp"); chk(K_ERR, 64'h0, "err_before");
        step();
        idle();
        chk(K_ERR, 64'h1, "err_set"); chk(K_D0, 64'h77, "r7_stored");
        chk(K_RDY, 64'h3, "r7_clamped_rdy");
        step();
        chk(K_ERR, 64'h1, "err_sticky");
        step();
        rst = 1'b1;
        chk(K_ERR, 64'h0, "err_rst"); chk(K_D0, 64'h0, "r7_rst_data");
        chk(K_RDY, 64'h3, "rst2_rdy"); chk(K_STALL, 64'h0, "rst2_stall");
        step();
        rst = 1'b0;
        chk(K_D0, 64'h0, "r7_post_rst"); chk(K_ERR, 64'h0, "err_post_rst");
        step();

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the Y86 pipeline register file: NUM_RD read ports, two write-back ports (E and M), and same-cycle write-to-read bypass.
- Adds a per-register in-flight write scoreboard so decode can stall on RAW hazards.
- Write-back ports carry the conditional-move suppression decided upstream.
- Sits between decode (reads, issue) and write-back (E/M retire).

Parameters:
- DATA_W, 64, register word width.
- NUM_REGS, 16, architectural registers; index NUM_REGS-1 is reserved as RNONE.
- ADDR_W, 4, register index width; $clog2(NUM_REGS).
- NUM_RD, 2, read ports.
- CNT_W, 2, per-register pending-write counter width; max in-flight writes is 2^CNT_W-1.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read indices, packed, port 0 in the LSBs.
- rd_data  out  NUM_RD*DATA_W  read data (combinational).
- rd_ready  out  NUM_RD  no pending write to the register, or it is retiring this cycle.
- iss_valid  in  1  decode issues an instruction this cycle.
- iss_dstE, iss_dstM  in  ADDR_W each  destinations to mark pending; RNONE means none.
- stall  out  1  issue cannot be accepted (counter would overflow).
- wbE_en  in  1  E-port retire.
- wbE_addr  in  ADDR_W  E-port destination.
- wbE_data  in  DATA_W  E-port data.
- wbE_cnd  in  1  condition result; 0 suppresses the data write.
- wbM_en, wbM_addr, wbM_data  in  1 / ADDR_W / DATA_W  M-port retire.
- flush  in  1  clear all pending counts (mispredict or exception).
- sb_err  out  1  sticky flag: retire seen with count already 0.

Behaviour:
- Reset (async, rst=1): all registers 0, all counts 0, sb_err 0. Outputs during reset: stall=0, rd_ready all 1, rd_data 0.
- Writes occur on the rising edge. E writes if wbE_en & wbE_cnd & addr!=RNONE. M writes if wbM_en & addr!=RNONE.
- E and M to the same address in the same cycle: M wins.
- Read path:
  - rd_addr==RNONE: data=0, ready=1.
  - Otherwise data = M write data if M writes that address this cycle, else E write data if E writes it, else the stored value.
  - Bypass latency is 0 cycles; stored latency is 1 cycle.
- Retire (count decrement): wbE_en with addr!=RNONE decrements the count regardless of wbE_cnd, so a suppressed cmov still frees the register. wbM_en decrements likewise.
- Issue (count increment): accepted only if iss_valid & !stall. Each non-RNONE dst adds 1. dstE==dstM adds 2 to that register.
- Net update per register: next = count + issues - retires, in the range -2..+2. A result below 0 clamps to 0 and sets sb_err (sticky until rst).
- stall (combinational): 1 if any issued dst's count - retires_this_cycle + increment > 2^CNT_W-1. Otherwise 0.
- rd_ready[i] = (count==0) | (count==number of retires this cycle to that address).
- flush: next cycle all counts are 0. Flush overrides issue and retire count updates in the same cycle. Data writes in the flush cycle still complete, and stall is forced to 0.
- Writes and reads never stall.
- Reset asserted mid-operation discards pending counts and data immediately.

Decomposition:
- Shared package regfile_pkg:
  - RNONE, IRRMOVL, IRMMOVL encodings.
  - reg_idx_t and word_t typedefs.
  - Default DATA_W and NUM_REGS.
- One sub-module, regfile_sb_cnt: a single register's saturating up/down counter with flush, clamp and underflow flag. Instantiated NUM_REGS-1 times via generate.
- Storage, bypass muxes and stall logic stay in the top level.

Test Plan:
- Reset then read r0..r14 -> all 0, rd_ready=1, stall=0; rd_addr=RNONE -> data 0.
- Write E r3=0x1111 and M r3=0x2222 in the same cycle, reading r3 that cycle -> rd_data=0x2222 (bypass, M wins); next cycle stored value is 0x2222.
- Issue dstE=r5, then wbE r5 with wbE_cnd=0, data 0xAA -> r5 unchanged, count returns to 0, rd_ready[r5]=1.
- Issue dstE=r2 three times, then a fourth issue with r2 -> stall=1 and count stays 3. A fourth issue coinciding with wbM r2 retire -> stall=0 and count stays 3.
- Issue dstE=dstM=r4 -> count 2, rd_ready=0. Assert flush with simultaneous issue r4 -> count 0 next cycle, rd_ready=1.
- wbE r7 retire with count 0 -> count stays 0, sb_err=1 and held. Assert rst -> sb_err=0.
